// File: rtl/vga_sync_if.sv
// VGA pixel-coordinate bundle from the timing generator to the renderer.
// The generator drives every signal; the renderer only reads them.
interface vga_sync_if;
  logic [10:0] x;
  logic [10:0] y;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic        p_tick;
  logic        frame_start;

  modport master (
    output x,
    output y,
    output hsync,
    output vsync,
    output video_on,
    output p_tick,
    output frame_start
  );

  modport slave (
    input x,
    input y,
    input hsync,
    input vsync,
    input video_on,
    input p_tick,
    input frame_start
  );
endinterface

// File: rtl/vga_sync.sv
// VGA 640x480@60Hz timing generator with registered, zero-skew sync decode.
// Define VGA_SYNC_PIPE_ALIGN_EN to delay hsync/vsync/video_on one clk (rgb align).
module vga_sync #(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic       clk,
  input  logic       reset,
  vga_sync_if.master bus
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE = DW'(1);

  localparam logic [10:0] X_MAX = 11'(H_TOT - 1);
  localparam logic [10:0] Y_MAX = 11'(V_TOT - 1);
  localparam logic [10:0] X_VIS = 11'(H_VIS);
  localparam logic [10:0] Y_VIS = 11'(V_VIS);
  localparam logic [10:0] HS_LO = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_HI = 11'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_LO = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_HI = 11'(V_VIS + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic          div_end;
  logic          tick;

  logic [10:0] x_q;
  logic [10:0] y_q;
  logic [10:0] x_nxt;
  logic [10:0] y_nxt;
  logic        x_wrap;
  logic        y_wrap;

  logic hs_q;
  logic vs_q;
  logic von_q;
  logic fs_q;
  logic hs_nxt;
  logic vs_nxt;
  logic von_nxt;
  logic fs_nxt;

  always_comb begin
    div_end = (div_cnt == DIV_MAX);
    tick    = div_end & ~reset;
    div_nxt = div_end ? '0 : div_cnt + DIV_ONE;
  end

  // frame_start is only set by a real wrap, never by reset.
  always_comb begin
    x_wrap = (x_q == X_MAX);
    y_wrap = (y_q == Y_MAX);
    x_nxt  = x_q;
    y_nxt  = y_q;
    fs_nxt = fs_q;
    if (tick) begin
      x_nxt  = x_wrap ? '0 : x_q + 11'd1;
      fs_nxt = x_wrap & y_wrap;
      if (x_wrap) begin
        y_nxt = y_wrap ? '0 : y_q + 11'd1;
      end
    end
  end

  // Decode from the next coordinates so the syncs land with x/y.
  always_comb begin
    hs_nxt  = ~((x_nxt >= HS_LO) && (x_nxt <= HS_HI));
    vs_nxt  = ~((y_nxt >= VS_LO) && (y_nxt <= VS_HI));
    von_nxt = (x_nxt < X_VIS) && (y_nxt < Y_VIS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      von_q   <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      x_q     <= x_nxt;
      y_q     <= y_nxt;
      hs_q    <= hs_nxt;
      vs_q    <= vs_nxt;
      von_q   <= von_nxt;
      fs_q    <= fs_nxt;
    end
  end

`ifdef VGA_SYNC_PIPE_ALIGN_EN
  logic hs_d;
  logic vs_d;
  logic von_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_d  <= 1'b1;
      vs_d  <= 1'b1;
      von_d <= 1'b1;
    end else begin
      hs_d  <= hs_q;
      vs_d  <= vs_q;
      von_d <= von_q;
    end
  end

  assign bus.hsync    = hs_d;
  assign bus.vsync    = vs_d;
  assign bus.video_on = von_d;
`else
  assign bus.hsync    = hs_q;
  assign bus.vsync    = vs_q;
  assign bus.video_on = von_q;
`endif

  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.p_tick      = tick;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: one full-size instance plus two shrunken-timing
// instances (CLK_DIV 1 and 2) so whole frames fit in a short run.
module tb_vga_sync;

`ifdef VGA_SYNC_PIPE_ALIGN_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [3];

  int checks   = 0;
  int failures = 0;

  vga_sync_if ia();
  vga_sync_if ib();
  vga_sync_if ic();

  vga_sync #(.CLK_DIV(2)) u0 (
    .clk(clk), .reset(rst[0]), .bus(ia)
  );

  vga_sync #(
    .CLK_DIV(1),
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u1 (
    .clk(clk), .reset(rst[1]), .bus(ib)
  );

  vga_sync #(
    .CLK_DIV(2),
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u2 (
    .clk(clk), .reset(rst[2]), .bus(ic)
  );

  logic [10:0] ox [3];
  logic [10:0] oy [3];
  logic ohs [3];
  logic ovs [3];
  logic ovo [3];
  logic opt [3];
  logic ofs [3];

  assign ox[0] = ia.x;  assign ox[1] = ib.x;  assign ox[2] = ic.x;
  assign oy[0] = ia.y;  assign oy[1] = ib.y;  assign oy[2] = ic.y;
  assign ohs[0] = ia.hsync;  assign ohs[1] = ib.hsync;
  assign ohs[2] = ic.hsync;
  assign ovs[0] = ia.vsync;  assign ovs[1] = ib.vsync;
  assign ovs[2] = ic.vsync;
  assign ovo[0] = ia.video_on;  assign ovo[1] = ib.video_on;
  assign ovo[2] = ic.video_on;
  assign opt[0] = ia.p_tick;  assign opt[1] = ib.p_tick;
  assign opt[2] = ic.p_tick;
  assign ofs[0] = ia.frame_start;  assign ofs[1] = ib.frame_start;
  assign ofs[2] = ic.frame_start;

  int p_div [3] = '{2, 1, 2};
  int p_hv  [3] = '{640, 8, 8};
  int p_hfp [3] = '{16, 2, 2};
  int p_hs  [3] = '{96, 3, 3};
  int p_hbp [3] = '{48, 3, 3};
  int p_vv  [3] = '{480, 6, 6};
  int p_vfp [3] = '{10, 1, 1};
  int p_vs  [3] = '{2, 2, 2};
  int p_vbp [3] = '{33, 2, 2};

  int mx [3];
  int my [3];
  int md [3];
  bit mfs [3];
  bit eh [3];
  bit ev [3];
  bit evo [3];
  bit ph [3];
  bit pv [3];
  bit pvo [3];
  int mism [3] = '{0, 0, 0};
  string mmsg [3];

  function automatic int ht(input int k);
    return p_hv[k] + p_hfp[k] + p_hs[k] + p_hbp[k];
  endfunction

  function automatic int vt(input int k);
    return p_vv[k] + p_vfp[k] + p_vs[k] + p_vbp[k];
  endfunction

  function automatic bit dec_h(input int k, input int x);
    int lo;
    lo = p_hv[k] + p_hfp[k];
    return !(x >= lo && x <= lo + p_hs[k] - 1);
  endfunction

  function automatic bit dec_v(input int k, input int y);
    int lo;
    lo = p_vv[k] + p_vfp[k];
    return !(y >= lo && y <= lo + p_vs[k] - 1);
  endfunction

  // Reference timing model, advanced once per rising edge.
  task automatic step(input int k);
    if (rst[k]) begin
      mx[k] = 0;  my[k] = 0;  md[k] = 0;  mfs[k] = 0;
      eh[k] = 1;  ev[k] = 1;  evo[k] = 1;
      ph[k] = 1;  pv[k] = 1;  pvo[k] = 1;
    end else begin
      ph[k] = eh[k];  pv[k] = ev[k];  pvo[k] = evo[k];
      if (md[k] == p_div[k] - 1) begin
        md[k] = 0;
        mfs[k] = (mx[k] == ht(k) - 1) && (my[k] == vt(k) - 1);
        if (mx[k] == ht(k) - 1) begin
          mx[k] = 0;
          my[k] = (my[k] == vt(k) - 1) ? 0 : my[k] + 1;
        end else begin
          mx[k] = mx[k] + 1;
        end
      end else begin
        md[k] = md[k] + 1;
      end
      eh[k]  = dec_h(k, mx[k]);
      ev[k]  = dec_v(k, my[k]);
      evo[k] = (mx[k] < p_hv[k]) && (my[k] < p_vv[k]);
    end
  endtask

  task automatic cmp(input int k);
    bit xh, xv, xo, xp;
    xh = (PIPE != 0) ? ph[k] : eh[k];
    xv = (PIPE != 0) ? pv[k] : ev[k];
    xo = (PIPE != 0) ? pvo[k] : evo[k];
    xp = (md[k] == p_div[k] - 1) && !rst[k];
    if (ox[k] !== 11'(mx[k]) || oy[k] !== 11'(my[k]) ||
        ohs[k] !== xh || ovs[k] !== xv || ovo[k] !== xo ||
        opt[k] !== xp || ofs[k] !== mfs[k]) begin
      if (mism[k] == 0)
        mmsg[k] = $sformatf(
          "t=%0t x=%0d/%0d y=%0d/%0d hs=%b/%b vs=%b/%b vo=%b/%b pt=%b/%b fs=%b/%b",
          $time, ox[k], mx[k], oy[k], my[k], ohs[k], xh, ovs[k], xv,
          ovo[k], xo, opt[k], xp, ofs[k], mfs[k]);
      mism[k]++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    for (int k = 0; k < 3; k++) step(k);
    @(negedge clk);
    for (int k = 0; k < 3; k++) cmp(k);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    checks++;
    if (ox[0] !== 11'd0 || oy[0] !== 11'd0) begin
      failures++;
      $display("FAIL reset_xy actual=%0d,%0d required=0,0", ox[0], oy[0]);
    end
    checks++;
    if ({ohs[0], ovs[0], ovo[0]} !== 3'b111) begin
      failures++;
      $display("FAIL reset_syncs actual=%b%b%b required=111",
               ohs[0], ovs[0], ovo[0]);
    end
    checks++;
    if ({opt[0], ofs[0]} !== 2'b00) begin
      failures++;
      $display("FAIL reset_strobes actual=%b%b required=00", opt[0], ofs[0]);
    end
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    #1;
    checks++;
    if (opt[0] !== 1'b0 || opt[1] !== 1'b1) begin
      failures++;
      $display("FAIL release_ptick actual=%b%b required=01", opt[0], opt[1]);
    end
    cyc();
    checks++;
    if (opt[0] !== 1'b1 || ox[0] !== 11'd0) begin
      failures++;
      $display("FAIL first_tick actual=pt%b x%0d required=pt1 x0",
               opt[0], ox[0]);
    end
    cyc();
    checks++;
    if (opt[0] !== 1'b0 || ox[0] !== 11'd1) begin
      failures++;
      $display("FAIL after_tick actual=pt%b x%0d required=pt0 x1",
               opt[0], ox[0]);
    end
  endtask

  task automatic test_line();
    int hs_fall_x = -1, hs_rise_x = -1, vo_fall_x = -1;
    int t656 = -100, tfall = -1, hs_len = -1;
    int wy = -1, wpy = -1;
    bit done = 0;
    int px, py;
    bit phs, pvo_l;
    for (int i = 0; i < 2000 && !done; i++) begin
      px = int'(ox[0]);  py = int'(oy[0]);
      phs = ohs[0];  pvo_l = ovo[0];
      cyc();
      if (int'(ox[0]) != px && ox[0] == 11'd656) t656 = i;
      if (phs && !ohs[0]) begin
        hs_fall_x = int'(ox[0]);
        tfall = i;
      end
      if (!phs && ohs[0]) begin
        hs_rise_x = int'(ox[0]);
        hs_len = i - tfall;
      end
      if (pvo_l && !ovo[0]) vo_fall_x = int'(ox[0]);
      if (px == 799 && ox[0] == 11'd0) begin
        wy = int'(oy[0]);
        wpy = py;
        done = 1;
      end
    end
    checks++;
    if (hs_fall_x !== 656) begin
      failures++;
      $display("FAIL hsync_fall_x actual=%0d required=656", hs_fall_x);
    end
    checks++;
    if (hs_rise_x !== 752) begin
      failures++;
      $display("FAIL hsync_rise_x actual=%0d required=752", hs_rise_x);
    end
    checks++;
    if (tfall - t656 !== PIPE) begin
      failures++;
      $display("FAIL hsync_skew actual=%0d required=%0d", tfall - t656, PIPE);
    end
    checks++;
    if (hs_len !== 192) begin
      failures++;
      $display("FAIL hsync_len actual=%0d required=192", hs_len);
    end
    checks++;
    if (vo_fall_x !== 640) begin
      failures++;
      $display("FAIL video_on_fall_x actual=%0d required=640", vo_fall_x);
    end
    checks++;
    if (!done || wpy !== 0 || wy !== 1) begin
      failures++;
      $display("FAIL line_wrap actual=done%0d y%0d->%0d required=done1 y0->1",
               done, wpy, wy);
    end
  endtask

  task automatic test_frame();
    int nr [3] = '{0, 0, 0};
    int tf [3] = '{0, 0, 0};
    int per [3] = '{-1, -1, -1};
    int fsl [3] = '{0, 0, 0};
    int vlo [3] = '{0, 0, 0};
    bit rok [3] = '{0, 0, 0};
    int ptl = 0;
    int px [3];
    int py [3];
    bit pfs [3];
    for (int i = 0; i < 1500 && !(nr[1] >= 2 && nr[2] >= 2); i++) begin
      for (int k = 1; k < 3; k++) begin
        px[k] = int'(ox[k]);  py[k] = int'(oy[k]);  pfs[k] = ofs[k];
      end
      cyc();
      if (!opt[1]) ptl++;
      for (int k = 1; k < 3; k++) begin
        if (!pfs[k] && ofs[k]) begin
          nr[k]++;
          if (nr[k] == 1) begin
            tf[k] = i;
            rok[k] = (ox[k] == 11'd0) && (oy[k] == 11'd0) &&
                     (px[k] == ht(k) - 1) && (py[k] == vt(k) - 1);
          end else if (nr[k] == 2) begin
            per[k] = i - tf[k];
          end
        end
        if (nr[k] == 1) begin
          if (ofs[k]) fsl[k]++;
          if (!ovs[k]) vlo[k]++;
        end
      end
    end
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (per[k] !== 176 * p_div[k]) begin
        failures++;
        $display("FAIL frame_period_dut%0d actual=%0d required=%0d",
                 k, per[k], 176 * p_div[k]);
      end
      checks++;
      if (fsl[k] !== p_div[k]) begin
        failures++;
        $display("FAIL frame_start_len_dut%0d actual=%0d required=%0d",
                 k, fsl[k], p_div[k]);
      end
      checks++;
      if (vlo[k] !== 32 * p_div[k]) begin
        failures++;
        $display("FAIL vsync_low_dut%0d actual=%0d required=%0d",
                 k, vlo[k], 32 * p_div[k]);
      end
      checks++;
      if (rok[k] !== 1'b1) begin
        failures++;
        $display("FAIL frame_wrap_dut%0d actual=%b required=1", k, rok[k]);
      end
    end
    checks++;
    if (ptl !== 0) begin
      failures++;
      $display("FAIL ptick_div1 actual_low_clks=%0d required=0", ptl);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    bit fs_seen = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      cyc();
      if (ox[0] == 11'd700) found = 1;
    end
    checks++;
    if (!found || ohs[0] !== 1'b0) begin
      failures++;
      $display("FAIL mid_hsync_pre actual=found%0d hs%b required=found1 hs0",
               found, ohs[0]);
    end
    rst[0] = 1'b1;
    cyc();
    checks++;
    if (ox[0] !== 11'd0 || oy[0] !== 11'd0 ||
        {ohs[0], ovs[0], ovo[0], ofs[0]} !== 4'b1110) begin
      failures++;
      $display("FAIL mid_reset_dut0 actual=x%0d y%0d hvof=%b%b%b%b required=x0 y0 hvof=1110",
               ox[0], oy[0], ohs[0], ovs[0], ovo[0], ofs[0]);
    end
    rst[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (ofs[0]) fs_seen = 1;
    end
    checks++;
    if (fs_seen || ox[0] !== 11'd5) begin
      failures++;
      $display("FAIL post_reset_run actual=fs%0d x%0d required=fs0 x5",
               fs_seen, ox[0]);
    end
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      cyc();
      if (ox[1] == 11'd11 && oy[1] == 11'd8) found = 1;
    end
    checks++;
    if (!found || ohs[1] !== 1'b0 || ovs[1] !== 1'b0) begin
      failures++;
      $display("FAIL mid_sync_pre_dut1 actual=found%0d hs%b vs%b required=found1 hs0 vs0",
               found, ohs[1], ovs[1]);
    end
    rst[1] = 1'b1;
    cyc();
    checks++;
    if (ox[1] !== 11'd0 || oy[1] !== 11'd0 ||
        {ohs[1], ovs[1], ofs[1]} !== 3'b110) begin
      failures++;
      $display("FAIL mid_reset_dut1 actual=x%0d y%0d hvf=%b%b%b required=x0 y0 hvf=110",
               ox[1], oy[1], ohs[1], ovs[1], ofs[1]);
    end
    rst[1] = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
  endtask

  task automatic test_model();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (mism[k] !== 0) begin
        failures++;
        $display("FAIL model_dut%0d mismatches=%0d first actual/required: %s",
                 k, mism[k], mmsg[k]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;
    test_reset();
    test_line();
    test_frame();
    test_reset_mid();
    test_model();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
